hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage vector core (IF/ID/EX/MEM/WB). It sits beside the instruction decoder.
- It consumes the decoded hazard addresses (HDU_A/HDU_B), destination register, write enable and branch class of the instruction in ID.
- It tracks in-flight register writers in a scoreboard and generates stall, bubble and flush controls for the PC, IF/ID and ID/EX registers.
- No forwarding exists in the datapath, so every RAW hazard is resolved by stalling.
- Branches (VBNZ/VBEZ) resolve in EX and are handled by a one-cycle wait/flush state machine.

---
 rtl/hazard_stall_controller_if.sv | 39 +++
 rtl/hazard_stall_controller.sv | 120 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Decode-side hazard inputs and pipeline control outputs of the stall controller.
// The master side is the decoder/pipeline; the slave side is the controller.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs_a;
  logic [4:0]       id_rs_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic [4:0]       id_rd;
  logic             id_wr_en;
  logic             id_is_branch;
  logic             ex_br_resolve;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             pc_sel_target;
  logic [CNT_W-1:0] stall_cycles;
  logic             br_timeout_err;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_rd, id_wr_en,
           id_is_branch, ex_br_resolve, ex_br_taken, mem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           pc_sel_target, stall_cycles, br_timeout_err
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_uses_a, id_uses_b, id_rd, id_wr_en,
           id_is_branch, ex_br_resolve, ex_br_taken, mem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           pc_sel_target, stall_cycles, br_timeout_err
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencing for a 5-stage pipeline without forwarding: a writer
// scoreboard resolves RAW hazards by stalling, and a small FSM waits on EX branches.
module hazard_stall_controller #(
  parameter int DEPTH      = 3,
  parameter int BR_TIMEOUT = 8,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  hazard_stall_controller_if.slave   ctl
);
  localparam int TO_W = (BR_TIMEOUT < 1) ? 1 : $clog2(BR_TIMEOUT + 1);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [DEPTH-1:0] sb_valid_reg, sb_valid_next;
  logic [4:0]       sb_rd_reg  [DEPTH];
  logic [4:0]       sb_rd_next [DEPTH];
  logic [DEPTH-1:0] match_a, match_b;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             br_err_reg;
  logic             hazard, issue, count_stall, to_clear, to_inc;

  // Entry 0 receives the issuing instruction (or a bubble); older entries age by one.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sb
      assign match_a[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == ctl.id_rs_a);
      assign match_b[gi] = sb_valid_reg[gi] && (sb_rd_reg[gi] == ctl.id_rs_b);
      if (gi == 0) begin : g_head
        assign sb_valid_next[gi] = issue && ctl.id_valid && ctl.id_wr_en;
        assign sb_rd_next[gi]    = ctl.id_rd;
      end else begin : g_tail
        assign sb_valid_next[gi] = sb_valid_reg[gi-1];
        assign sb_rd_next[gi]    = sb_rd_reg[gi-1];
      end
    end
  endgenerate

  assign hazard = ctl.id_valid && ((ctl.id_uses_a && (|match_a)) ||
                                   (ctl.id_uses_b && (|match_b)));

  always_comb begin
    state_next        = state_reg;
    ctl.pc_stall      = 1'b0;
    ctl.ifid_stall    = 1'b0;
    ctl.ifid_flush    = 1'b0;
    ctl.idex_bubble   = 1'b0;
    ctl.pipe_freeze   = 1'b0;
    ctl.pc_sel_target = 1'b0;
    issue             = 1'b0;
    count_stall       = 1'b0;
    to_clear          = 1'b0;
    to_inc            = 1'b0;
    if (reset) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_bubble = 1'b1;
    end else if (ctl.mem_busy) begin
      ctl.pipe_freeze = 1'b1;
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
    end else if (state_reg == BR_WAIT && !ctl.ex_br_resolve) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_bubble = 1'b1;
      to_inc          = 1'b1;
    end else if (state_reg == BR_WAIT && ctl.ex_br_taken) begin
      // Fall-through in ID is wrong-path: kill it regardless of hazards.
      ctl.ifid_flush    = 1'b1;
      ctl.idex_bubble   = 1'b1;
      ctl.pc_sel_target = 1'b1;
      state_next        = RUN;
    end else if (hazard) begin
      ctl.pc_stall    = 1'b1;
      ctl.ifid_stall  = 1'b1;
      ctl.idex_bubble = 1'b1;
      count_stall     = 1'b1;
      state_next      = RUN;
    end else begin
      issue = 1'b1;
      if (ctl.id_valid && ctl.id_is_branch) begin
        state_next = BR_WAIT;
        to_clear   = 1'b1;
      end else begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      sb_valid_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd_reg[i] <= '0;
      stall_cycles_reg <= '0;
      to_cnt_reg       <= '0;
      br_err_reg       <= 1'b0;
    end else if (!ctl.mem_busy) begin
      state_reg    <= state_next;
      sb_valid_reg <= sb_valid_next;
      sb_rd_reg    <= sb_rd_next;
      if (count_stall && (stall_cycles_reg != {CNT_W{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (to_clear) begin
        to_cnt_reg <= '0;
      end else if (to_inc) begin
        if (to_cnt_reg < TO_W'(BR_TIMEOUT))
          to_cnt_reg <= to_cnt_reg + TO_W'(1);
        if (to_cnt_reg >= TO_W'(BR_TIMEOUT - 1))
          br_err_reg <= 1'b1;
      end
    end
  end

  assign ctl.stall_cycles   = stall_cycles_reg;
  assign ctl.br_timeout_err = br_err_reg;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed stimulus against a timing-based reference model;
// expected per-cycle controls go into a queue consumed by an independent monitor.
module tb_hazard_stall_controller;
  localparam int DEPTH      = 3;
  localparam int BR_TIMEOUT = 8;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(
    .DEPTH(DEPTH), .BR_TIMEOUT(BR_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ctl(bus.slave)
  );

  // ctrl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_sel_target}
  typedef struct {
    int               cyc;
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_no = 0;

  // Reference model: a write to r issued at pipeline time t blocks readers of r
  // during pipeline times t+1..t+DEPTH; pipeline time only advances when not frozen.
  longint ptime;
  longint last_issue [32];
  bit     m_br_wait;
  int     m_wait;
  bit     m_err;
  int     m_stalls;

  function automatic void model_reset();
    ptime = 0;
    for (int r = 0; r < 32; r++) last_issue[r] = -1000;
    m_br_wait = 0;
    m_wait    = 0;
    m_err     = 0;
    m_stalls  = 0;
  endfunction

  function automatic bit m_hit(input logic [4:0] r);
    longint d;
    d = ptime - last_issue[r];
    return (d >= 1) && (d <= DEPTH);
  endfunction

  task automatic cyc(input bit rst, input bit v, input logic [4:0] ra, input bit ua,
                     input logic [4:0] rb, input bit ub, input logic [4:0] rd,
                     input bit we, input bit br, input bit res, input bit tk,
                     input bit busy);
    exp_t e;
    bit   haz;
    @(negedge clk);
    reset             = rst;
    bus.id_valid      = v;
    bus.id_rs_a       = ra;
    bus.id_uses_a     = ua;
    bus.id_rs_b       = rb;
    bus.id_uses_b     = ub;
    bus.id_rd         = rd;
    bus.id_wr_en      = we;
    bus.id_is_branch  = br;
    bus.ex_br_resolve = res;
    bus.ex_br_taken   = tk;
    bus.mem_busy      = busy;
    #1;
    cyc_no++;
    e.cyc = cyc_no;
    if (rst) begin
      model_reset();
      e.ctrl = 6'b110100;
      e.cnt  = '0;
      e.err  = 1'b0;
      exp_q.push_back(e);
      return;
    end
    e.cnt = m_stalls[CNT_W-1:0];
    e.err = m_err;
    if (busy) begin
      e.ctrl = 6'b110010;
    end else begin
      haz = v && ((ua && m_hit(ra)) || (ub && m_hit(rb)));
      if (m_br_wait && !res) begin
        e.ctrl = 6'b110100;
        m_wait++;
        if (m_wait >= BR_TIMEOUT) m_err = 1;
      end else if (m_br_wait && tk) begin
        e.ctrl    = 6'b001101;
        m_br_wait = 0;
      end else if (haz) begin
        e.ctrl = 6'b110100;
        if (m_stalls < (1 << CNT_W) - 1) m_stalls++;
        m_br_wait = 0;
      end else begin
        e.ctrl = 6'b000000;
        if (v && we) last_issue[rd] = ptime;
        m_br_wait = v && br;
        m_wait    = 0;
      end
      ptime++;
    end
    exp_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: samples outputs 2 time units after the falling edge.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble,
               bus.pipe_freeze, bus.pc_sel_target};
        total += 3;
        if (act !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl cyc=%0d actual=%b required=%b", e.cyc, act, e.ctrl);
        end
        if (bus.stall_cycles !== e.cnt) begin
          bad++;
          $display("FAIL stall_cycles cyc=%0d actual=%0d required=%0d", e.cyc, bus.stall_cycles, e.cnt);
        end
        if (bus.br_timeout_err !== e.err) begin
          bad++;
          $display("FAIL br_timeout_err cyc=%0d actual=%b required=%b", e.cyc, bus.br_timeout_err, e.err);
        end
        $display("cyc=%0d ctrl=%b stalls=%0d err=%b", e.cyc, act, bus.stall_cycles, bus.br_timeout_err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pres;
    bit  v, res;
    model_reset();
    cyc(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    nop(2);

    // RAW on rs_a: writer r5, reader held in ID until it issues.
    cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    nop(4);

    // rs_b ignored when unused, then honoured when used.
    cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'd7, 1, 5'd5, 0, 5'd8, 1, 0, 0, 0, 0);
    nop(4);
    cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 5'd7, 1, 5'd5, 1, 5'd8, 1, 0, 0, 0, 0);
    nop(4);

    // Taken branch: fall-through writer r9 is killed, so a later r9 reader must not stall.
    cyc(0, 1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0);
    cyc(0, 1, 5'd2, 1, 5'd3, 1, 5'd9, 1, 0, 1, 1, 0);
    cyc(0, 1, 5'd9, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, 0);
    nop(4);

    // Not-taken branch after a load to r3, fall-through reads r3.
    cyc(0, 1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'd2, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0);
    cyc(0, 1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 1, 0, 0);
    repeat (3) cyc(0, 1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, 0);
    nop(4);

    // mem_busy for 4 cycles in the middle of a RAW stall.
    cyc(0, 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    nop(4);

    // Branch timeout, then reset asserted during a RAW stall.
    cyc(0, 1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0);
    repeat (10) cyc(0, 1, 5'd2, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'd2, 1, 5'd0, 0, 5'd4, 1, 0, 1, 0, 0);
    cyc(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    cyc(1, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    cyc(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
    nop(2);

    // Random phases with varying branch-resolve probability.
    for (int i = 0; i < 1500; i++) begin
      pres = (i / 300) % 2 == 0 ? 40 : 6;
      v    = ($urandom_range(0, 99) < 80);
      res  = ($urandom_range(0, 99) < pres);
      cyc(($urandom_range(0, 199) == 0),
          v,
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 20),
          res, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 99) < 12));
    end
    nop(2);

    @(negedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
